// File: rtl/apb4_master_pkg.sv
// Shared types and default sizing for the APB4 master bridge.
package apb4_master_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_TMO_CYC    = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Wait-counter width; a disabled timeout still needs a 1-bit vector.
    function automatic int unsigned tmo_cnt_width(input int unsigned tmo);
        return (tmo > 0) ? $clog2(tmo + 1) : 1;
    endfunction

endpackage

// File: rtl/apb4_mst_tmo.sv
// Clearable, saturating ACCESS wait counter with a combinational expiry flag.
module apb4_mst_tmo
    import apb4_master_pkg::*;
#(
    parameter int unsigned TMO_CYC = DEF_TMO_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire_c
);

    localparam int unsigned CW   = tmo_cnt_width(TMO_CYC);
    localparam int unsigned LAST = (TMO_CYC > 0) ? TMO_CYC - 1 : 0;

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CW'(TMO_CYC))) begin
            count <= count + CW'(1);
        end
    end

    // Fires on the wait cycle that would make the count reach the limit.
    assign expire_c = (TMO_CYC != 0) && inc && (count == CW'(LAST));

endmodule

// File: rtl/apb4_master_bridge.sv
// Single-outstanding APB4 initiator: valid/ready request in, APB4 transfer,
// valid/ready response out with slave-error and timeout status.
module apb4_master_bridge
    import apb4_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned TMO_CYC    = DEF_TMO_CYC
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    input  logic [2:0]              req_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_tmo,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [2:0]              pprot,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic                    pready,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pslverr
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    state_t state;
    state_t state_next;
    logic   accept_c;
    logic   done_c;
    logic   wait_c;
    logic   expire_c;

    assign wait_c = (state == ACCESS) && !pready;

    apb4_mst_tmo #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo (
        .clk      (pclk),
        .rst      (preset),
        .clr      (accept_c),
        .inc      (wait_c),
        .expire_c (expire_c)
    );

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept_c   = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                // pready on the limit cycle completes normally
                if (pready) begin
                    done_c     = 1'b1;
                    state_next = RESP;
                end else if (expire_c) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // APB phase controls follow the next state so they are glitch-free.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            psel    <= 1'b0;
            penable <= 1'b0;
        end else begin
            psel    <= (state_next == SETUP) || (state_next == ACCESS);
            penable <= (state_next == ACCESS);
        end
    end

    // Transfer payload is loaded only on acceptance and held otherwise.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            paddr  <= '0;
            pwrite <= 1'b0;
            pwdata <= '0;
            pstrb  <= '0;
            pprot  <= '0;
        end else if (accept_c) begin
            paddr  <= req_addr;
            pwrite <= req_write;
            pwdata <= req_wdata;
            pstrb  <= req_write ? req_strb : STRB_WIDTH'(0);
            pprot  <= req_prot;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_tmo   <= 1'b0;
        end else if (done_c) begin
            rsp_rdata <= (pwrite || pslverr) ? DATA_WIDTH'(0) : prdata;
            rsp_err   <= pslverr;
            rsp_tmo   <= 1'b0;
        end else if (expire_c) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_tmo   <= 1'b1;
        end
    end

endmodule

// File: doc/apb4_master_bridge.md
# apb4_master_bridge

Single-outstanding APB4 initiator: converts a valid/ready request channel into APB4 SETUP/ACCESS transfers and returns read data, slave error and timeout status on a valid/ready response channel. Sits between an internal controller (boot sequencer, debug port) and the APB4 peripheral fabric that hosts register slaves such as the architecture-info block.

## Interface
Parameters:
- ADDR_WIDTH, 32, APB address width
- DATA_WIDTH, 32, APB data width (multiple of 8)
- TMO_CYC, 256, max ACCESS cycles waiting for pready; 0 disables the timeout

Ports:
- pclk  in  1  clock
- preset  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when both high
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  write data
- req_strb  in  DATA_WIDTH/8  write byte strobes
- req_prot  in  3  forwarded to pprot
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes, errors and timeouts)
- rsp_err  out  1  pslverr sampled or timeout
- rsp_tmo  out  1  timeout occurred
- paddr  out  ADDR_WIDTH; pprot out 3; psel out 1; penable out 1; pwrite out 1; pwdata out DATA_WIDTH; pstrb out DATA_WIDTH/8
- pready  in  1; prdata in DATA_WIDTH; pslverr in 1

## Operation
- FSM states IDLE, SETUP, ACCESS, RESP; reset state IDLE.
- IDLE: req_ready=1. On req_valid: capture write/addr/wdata/strb/prot into APB output registers, go SETUP. pstrb forced to 0 for reads.
- SETUP: psel=1, penable=0, exactly one cycle, go ACCESS.
- ACCESS: psel=1, penable=1. pready=1: capture prdata (reads only), pslverr into rsp_err, rsp_tmo=0, go RESP. pready=0: increment wait counter.
- Timeout: TMO_CYC≠0 and counter reaches TMO_CYC with pready still 0 → drop psel/penable, rsp_err=1, rsp_tmo=1, rsp_rdata=0, go RESP. pready=1 in the same cycle as the limit wins (normal completion).
- RESP: rsp_valid=1, rsp_* stable until rsp_ready; then IDLE. psel=penable=0.
- req_ready=0 in SETUP/ACCESS/RESP; no request is accepted while a response is pending.
- paddr/pwrite/pwdata/pstrb/pprot held constant from SETUP through the last ACCESS cycle; retain value in IDLE/RESP (no toggling).
- Counter clears on entry to SETUP; width $clog2(TMO_CYC+1), saturating.
- Write responses: rsp_rdata=0 regardless of prdata.

## Timing
- All outputs registered except req_ready and rsp_valid (decoded from state register only).
- Reset values: state IDLE, req_ready=1, psel=penable=pwrite=0, paddr=pwdata=pstrb=pprot=0, rsp_valid=rsp_err=rsp_tmo=0, rsp_rdata=0.
- Zero-wait transfer: accept at cycle 0, SETUP cycle 1, ACCESS cycle 2, rsp_valid at cycle 3. Each pready=0 cycle adds one.
- Minimum request-to-request spacing 4 cycles (rsp_ready tied high).
- Reset asserted mid-transfer: psel/penable drop asynchronously, pending response discarded, FSM IDLE.

## Structure
- Package apb4_master_pkg: state enum (IDLE, SETUP, ACCESS, RESP), default widths, TMO_CYC default.
- Output/capture registers built from the team's dffr/dfferc-style cells.
- One sub-module: apb4_mst_tmo (clearable, saturating wait counter, outputs expiry flag).

## Test plan
- Read addr 0x0000_0004, slave pready=1, prdata=0xA5A5_0001 → psel at cycle 1, penable cycle 2, rsp_valid cycle 3, rsp_rdata=0xA5A5_0001, rsp_err=0.
- Write addr 0x8, wdata 0x1234_5678, strb 0xF, pready low 3 cycles → ACCESS lasts 4 cycles, pwdata/paddr stable throughout, rsp_rdata=0, rsp_err=0.
- Read with pslverr=1 at completion → rsp_err=1, rsp_tmo=0, rsp_rdata=0.
- TMO_CYC=4, pready stuck 0 → after 4 ACCESS cycles psel drops, rsp_err=1, rsp_tmo=1; pready=1 exactly at limit → normal completion instead.
- rsp_ready held 0 for 5 cycles with req_valid=1 → req_ready stays 0, response stable, no new psel; rsp_ready=1 → next request accepted following cycle.
- preset pulsed during ACCESS → psel/penable=0 same cycle, rsp_valid=0, req_ready=1 after release.
